// File: rtl/shapool_host_spi.sv
`default_nettype none
// ============================================================================
// Module      : shapool_host_spi
// Description : Host SPI master for shapool devices. Sends one job word on the
//               global bus, waits for ready, then reads the daisy result chain.
// Revision    : 1.0 - initial release
// ============================================================================
module shapool_host_spi #(
  parameter int JOB_BITS       = 352,
  parameter int RESULT_BITS    = 40,
  parameter int CHAIN_LEN      = 1,
  parameter int SCK_DIV        = 4,
  parameter int TIMEOUT_CYCLES = 2**28
) (
  input  logic                            clk_in,
  input  logic                            reset_n_in,
  input  logic                            start_in,
  input  logic                            abort_in,
  input  logic [JOB_BITS-1:0]             job_in,
  output logic                            busy_out,
  output logic                            done_out,
  output logic                            timeout_out,
  output logic [RESULT_BITS*CHAIN_LEN-1:0] result_out,
  output logic                            sck0_out,
  output logic                            sdo0_out,
  output logic                            cs0_n_out,
  output logic                            sck1_out,
  output logic                            sdo1_out,
  input  logic                            sdi1_in,
  output logic                            cs1_n_out,
  input  logic                            ready_n_in
);

  localparam int RES_BITS = RESULT_BITS * CHAIN_LEN;
  localparam int MAX_BITS = (JOB_BITS > RES_BITS) ? JOB_BITS : RES_BITS;
  localparam int BIT_W    = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
  localparam int HALF_W   = $clog2(SCK_DIV);
  localparam int WAIT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [BIT_W-1:0]  c_job_last  = BIT_W'(JOB_BITS - 1);
  localparam logic [BIT_W-1:0]  c_res_last  = BIT_W'(RES_BITS - 1);
  localparam logic [BIT_W-1:0]  c_bit_one   = BIT_W'(1);
  localparam logic [HALF_W-1:0] c_half_last = HALF_W'(SCK_DIV - 1);
  localparam logic [HALF_W-1:0] c_half_one  = HALF_W'(1);
  localparam logic [WAIT_W-1:0] c_wait_last = WAIT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WAIT_W-1:0] c_wait_one  = WAIT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_JOB_SHIFT  = 3'd1,
    S_JOB_GAP    = 3'd2,
    S_WAIT_READY = 3'd3,
    S_RES_SHIFT  = 3'd4,
    S_FINISH     = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [1:0]          r_rdy_sync;
  logic [JOB_BITS-1:0] r_job;
  logic [RES_BITS-1:0] r_cap;
  logic [RES_BITS-1:0] r_result;
  logic [BIT_W-1:0]    r_bit;
  logic [HALF_W-1:0]   r_half;
  logic                r_tail;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic                r_to_flag;
  logic                r_sck0;
  logic                r_sdo0;
  logic                r_cs0_n;
  logic                r_sck1;
  logic                r_cs1_n;

  logic w_ready;
  logic w_accept;
  logic w_abort;
  logic w_half_end;
  logic w_in_job;
  logic w_in_res;
  logic w_shifting;
  logic w_sck;
  logic w_bit_last;
  logic w_rise;
  logic w_fall;
  logic w_frame_end;
  logic w_wait_expired;

  assign w_ready        = ~r_rdy_sync[1];
  assign w_accept       = (r_state == S_IDLE) & start_in & ~abort_in;
  assign w_abort        = (r_state != S_IDLE) & abort_in;
  assign w_half_end     = (r_half == c_half_last);
  assign w_in_job       = (r_state == S_JOB_SHIFT);
  assign w_in_res       = (r_state == S_RES_SHIFT);
  assign w_shifting     = w_in_job | w_in_res;
  assign w_sck          = w_in_job ? r_sck0 : r_sck1;
  assign w_bit_last     = w_in_job ? (r_bit == c_job_last) : (r_bit == c_res_last);
  // r_tail marks the trailing low half-period that keeps CS asserted after the last bit
  assign w_rise         = w_shifting & w_half_end & ~r_tail & ~w_sck;
  assign w_fall         = w_shifting & w_half_end & ~r_tail & w_sck;
  assign w_frame_end    = w_shifting & w_half_end & r_tail;
  assign w_wait_expired = (r_wait_cnt == c_wait_last);

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:       if (w_accept) w_state_nxt = S_JOB_SHIFT;
        S_JOB_SHIFT:  if (w_frame_end) w_state_nxt = S_JOB_GAP;
        S_JOB_GAP:    if (w_half_end) w_state_nxt = S_WAIT_READY;
        S_WAIT_READY: begin
          if (w_ready) begin
            w_state_nxt = S_RES_SHIFT;
          end else if (w_wait_expired) begin
            w_state_nxt = S_FINISH;
          end
        end
        S_RES_SHIFT:  if (w_frame_end) w_state_nxt = S_FINISH;
        S_FINISH:     w_state_nxt = S_IDLE;
        default:      w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_rdy_sync <= 2'b11;
      r_job      <= '0;
      r_cap      <= '0;
      r_result   <= '0;
      r_bit      <= '0;
      r_half     <= '0;
      r_tail     <= 1'b0;
      r_wait_cnt <= '0;
      r_to_flag  <= 1'b0;
      r_sck0     <= 1'b0;
      r_sdo0     <= 1'b0;
      r_cs0_n    <= 1'b1;
      r_sck1     <= 1'b0;
      r_cs1_n    <= 1'b1;
    end else begin
      r_rdy_sync <= {r_rdy_sync[0], ready_n_in};
      if (w_abort) begin
        r_cs0_n <= 1'b1;
        r_cs1_n <= 1'b1;
        r_sck0  <= 1'b0;
        r_sck1  <= 1'b0;
        r_sdo0  <= 1'b0;
        r_half  <= '0;
        r_bit   <= '0;
        r_tail  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              // MSB goes straight to the pin; the rest waits one position up
              r_job     <= {job_in[JOB_BITS-2:0], 1'b0};
              r_sdo0    <= job_in[JOB_BITS-1];
              r_cs0_n   <= 1'b0;
              r_half    <= '0;
              r_bit     <= '0;
              r_tail    <= 1'b0;
              r_to_flag <= 1'b0;
            end
          end
          S_JOB_SHIFT, S_RES_SHIFT: begin
            r_half <= w_half_end ? '0 : r_half + c_half_one;
            if (w_rise) begin
              if (w_in_job) r_sck0 <= 1'b1;
              else          r_sck1 <= 1'b1;
            end
            if (w_fall) begin
              if (w_in_job) begin
                r_sck0 <= 1'b0;
                r_sdo0 <= r_job[JOB_BITS-1];
                r_job  <= {r_job[JOB_BITS-2:0], 1'b0};
              end else begin
                r_sck1 <= 1'b0;
                r_cap  <= {r_cap[RES_BITS-2:0], sdi1_in};
              end
              if (w_bit_last) r_tail <= 1'b1;
              else            r_bit  <= r_bit + c_bit_one;
            end
            if (w_frame_end) begin
              r_tail <= 1'b0;
              r_bit  <= '0;
              if (w_in_job) begin
                r_cs0_n <= 1'b1;
              end else begin
                r_cs1_n  <= 1'b1;
                r_result <= r_cap;
              end
            end
          end
          S_JOB_GAP: begin
            r_half     <= w_half_end ? '0 : r_half + c_half_one;
            r_wait_cnt <= '0;
          end
          S_WAIT_READY: begin
            if (w_ready) begin
              r_cs1_n <= 1'b0;
              r_half  <= '0;
              r_bit   <= '0;
              r_tail  <= 1'b0;
            end else if (w_wait_expired) begin
              r_to_flag <= 1'b1;
            end else begin
              r_wait_cnt <= r_wait_cnt + c_wait_one;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign busy_out    = (r_state != S_IDLE) && (r_state != S_FINISH);
  assign done_out    = (r_state == S_FINISH);
  assign timeout_out = (r_state == S_FINISH) && r_to_flag;
  assign result_out  = r_result;
  assign sck0_out    = r_sck0;
  assign sdo0_out    = r_sdo0;
  assign cs0_n_out   = r_cs0_n;
  assign sck1_out    = r_sck1;
  assign sdo1_out    = 1'b0;
  assign cs1_n_out   = r_cs1_n;

endmodule
`default_nettype wire

// File: tb/tb_shapool_host_spi.sv
`default_nettype none
// ============================================================================
// Module      : tb_shapool_host_spi
// Description : Self-checking bench for shapool_host_spi with a frame-timing
//               model and a simple daisy-chain device model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shapool_host_spi;

  localparam int J  = 16;
  localparam int R  = 8;
  localparam int C  = 2;
  localparam int N  = R * C;
  localparam int SD = 2;
  localparam int TO = 100;
  localparam int JL = SD * (2 * J + 1);
  localparam int RL = SD * (2 * N + 1);

  logic         clk_in     = 1'b0;
  logic         reset_n_in = 1'b1;
  logic         start_in   = 1'b0;
  logic         abort_in   = 1'b0;
  logic [J-1:0] job_in     = '0;
  logic         sdi1_in    = 1'b0;
  logic         ready_n_in = 1'b1;
  logic         busy_out, done_out, timeout_out;
  logic [N-1:0] result_out;
  logic         sck0_out, sdo0_out, cs0_n_out, sck1_out, sdo1_out, cs1_n_out;

  shapool_host_spi #(
    .JOB_BITS(J), .RESULT_BITS(R), .CHAIN_LEN(C), .SCK_DIV(SD), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_in(clk_in), .reset_n_in(reset_n_in), .start_in(start_in), .abort_in(abort_in),
    .job_in(job_in), .busy_out(busy_out), .done_out(done_out), .timeout_out(timeout_out),
    .result_out(result_out), .sck0_out(sck0_out), .sdo0_out(sdo0_out), .cs0_n_out(cs0_n_out),
    .sck1_out(sck1_out), .sdo1_out(sdo1_out), .sdi1_in(sdi1_in), .cs1_n_out(cs1_n_out),
    .ready_n_in(ready_n_in)
  );

  always #5 clk_in = ~clk_in;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- device model: response shifter and ready line ----------
  logic [N-1:0] resp      = '0;
  int           rdy_delay = -2;   // -2 held low, -1 never ready, else cycles after cs0_n rises
  int           rdy_cd    = -1;
  int           dev_cnt   = 0;
  logic         dev_p_sck1 = 1'b0;
  logic         dev_p_cs0  = 1'b1;

  always @(negedge clk_in) begin
    if (cs1_n_out) begin
      dev_cnt = 0;
      sdi1_in = resp[N-1];
    end else begin
      if (dev_p_sck1 && !sck1_out) dev_cnt++;
      sdi1_in = (dev_cnt < N) ? resp[N-1-dev_cnt] : 1'b0;
    end
    dev_p_sck1 = sck1_out;

    if (rdy_delay == -2) begin
      ready_n_in = 1'b0;
    end else if (!cs0_n_out) begin
      ready_n_in = 1'b1;
      rdy_cd     = -1;
    end else begin
      if (!dev_p_cs0) rdy_cd = rdy_delay;
      if (rdy_cd == 0) ready_n_in = 1'b0;
      else if (rdy_cd > 0) rdy_cd--;
    end
    dev_p_cs0 = cs0_n_out;
  end

  // ---------------- behavioural model: phase + cycles elapsed in phase ------
  // m_mode: 0 idle, 1 job frame, 2 gap, 3 waiting, 4 result frame, 5 finish
  int           m_mode = 0;
  int           m_k    = 0;
  logic [J-1:0] m_job  = '0;
  logic [N-1:0] m_result = '0;
  bit           m_to   = 0;
  logic         m_h0 = 1'b1, m_h1 = 1'b1;

  always @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      m_mode = 0; m_k = 0; m_result = '0; m_to = 0; m_h0 = 1'b1; m_h1 = 1'b1;
    end else begin
      bit seen;
      seen = !m_h1;             // controller sees ready_n two edges late
      m_h1 = m_h0;
      m_h0 = ready_n_in;
      if (abort_in && m_mode != 0) begin
        m_mode = 0; m_k = 0;
      end else begin
        case (m_mode)
          0: if (start_in && !abort_in) begin m_mode = 1; m_k = 1; m_job = job_in; end
          1: if (m_k == JL) begin m_mode = 2; m_k = 1; end else m_k++;
          2: if (m_k == SD) begin m_mode = 3; m_k = 1; end else m_k++;
          3: if (seen) begin m_mode = 4; m_k = 1; end
             else if (m_k == TO) begin m_mode = 5; m_to = 1; end
             else m_k++;
          4: if (m_k == RL) begin m_mode = 5; m_to = 0; m_result = resp; end else m_k++;
          default: m_mode = 0;
        endcase
      end
    end
  end

  always @(negedge clk_in) begin
    if (reset_n_in) begin
      int idx, b;
      logic e_sck0, e_sck1;
      e_sck0 = 1'b0;
      e_sck1 = 1'b0;
      if (m_mode == 1) begin
        idx = m_k - 1; b = idx / (2 * SD);
        e_sck0 = (b < J) && ((idx % (2 * SD)) >= SD);
        if (b < J) check("sdo0_bit", sdo0_out, m_job[J-1-b]);
      end
      if (m_mode == 4) begin
        idx = m_k - 1; b = idx / (2 * SD);
        e_sck1 = (b < N) && ((idx % (2 * SD)) >= SD);
      end
      check("busy", busy_out, (m_mode >= 1 && m_mode <= 4));
      check("done", done_out, (m_mode == 5));
      check("timeout", timeout_out, (m_mode == 5) && m_to);
      check("cs0_n", cs0_n_out, (m_mode != 1));
      check("cs1_n", cs1_n_out, (m_mode != 4));
      check("sck0", sck0_out, e_sck0);
      check("sck1", sck1_out, e_sck1);
      check("sdo1", sdo1_out, 1'b0);
      check("result", result_out, m_result);
    end
  end

  // ---------------- monitors for directed literal checks -------------------
  int           cyc = 0, n_r0 = 0, n_r1 = 0, n_cs0_low = 0, n_cs0_fall = 0;
  int           n_done = 0, n_to = 0, t_cs0_rise = 0, t_done = 0;
  logic [J-1:0] bits0 = '0;
  logic         p_sck0 = 1'b0, p_sck1 = 1'b0, p_cs0 = 1'b1;

  always @(negedge clk_in) begin
    cyc++;
    if (sck0_out && !p_sck0) begin n_r0++; bits0 = {bits0[J-2:0], sdo0_out}; end
    if (sck1_out && !p_sck1) n_r1++;
    if (!cs0_n_out) n_cs0_low++;
    if (!cs0_n_out && p_cs0) n_cs0_fall++;
    if (cs0_n_out && !p_cs0) t_cs0_rise = cyc;
    if (done_out) begin n_done++; t_done = cyc; end
    if (timeout_out) n_to++;
    p_sck0 = sck0_out; p_sck1 = sck1_out; p_cs0 = cs0_n_out;
  end

  // ---------------- stimulus ------------------------------------------------
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic pulse_start(input logic [J-1:0] j);
    job_in   = j;
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
  endtask

  task automatic wait_done(input int bound, output bit got);
    got = 0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (done_out === 1'b1) begin got = 1; break; end
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, busy_out, 1'b0);
    check({tag, "_done"}, done_out, 1'b0);
    check({tag, "_timeout"}, timeout_out, 1'b0);
    check({tag, "_result"}, result_out, '0);
    check({tag, "_pins"}, {sck0_out, sdo0_out, cs0_n_out, sck1_out, sdo1_out, cs1_n_out}, 6'b001001);
  endtask

  initial begin
    bit got;
    int s_r0, s_r1, s_low, s_fall, s_done, s_to, rc, abort_at;
    logic p;

    #1 reset_n_in = 1'b0;
    #1 check_reset_values("reset");
    repeat (3) tick();
    reset_n_in = 1'b1;
    repeat (3) tick();

    // job shift with ready already low
    resp = 16'h1234; rdy_delay = -2;
    s_r0 = n_r0; s_r1 = n_r1; s_low = n_cs0_low; s_done = n_done; s_to = n_to;
    pulse_start(16'hA5C3);
    wait_done(400, got);
    check("job_done_seen", got, 1'b1);
    check("job_timeout", timeout_out, 1'b0);
    check("job_result", result_out, 16'h1234);
    tick();
    check("job_sck0_rises", n_r0 - s_r0, 16);
    check("job_bits", bits0, 16'hA5C3);
    check("job_cs0_low", n_cs0_low - s_low, 66);
    check("job_sck1_rises", n_r1 - s_r1, 16);
    check("job_done_count", n_done - s_done, 1);
    check("job_to_count", n_to - s_to, 0);

    // timeout
    resp = 16'hFFFF; rdy_delay = -1;
    s_r1 = n_r1; s_to = n_to;
    pulse_start(16'h0001);
    wait_done(400, got);
    check("to_done_seen", got, 1'b1);
    check("to_timeout", timeout_out, 1'b1);
    check("to_result_kept", result_out, 16'h1234);
    tick();
    check("to_latency", t_done - t_cs0_rise, SD + TO);
    check("to_sck1_rises", n_r1 - s_r1, 0);
    check("to_count", n_to - s_to, 1);

    // start and abort together in idle: dropped
    rdy_delay = -2;
    start_in = 1'b1; abort_in = 1'b1; job_in = 16'hBEEF;
    tick();
    start_in = 1'b0; abort_in = 1'b0;
    check("startabort_busy", busy_out, 1'b0);
    check("startabort_cs0", cs0_n_out, 1'b1);

    // abort at 5th sck0 rise
    resp = 16'h5A0F;
    pulse_start(16'h0F0F);
    rc = 0; p = 1'b0;
    for (int i = 0; i < 100 && rc < 5; i++) begin
      tick();
      if (sck0_out && !p) rc++;
      p = sck0_out;
    end
    check("abort_reached_rise5", rc, 5);
    abort_in = 1'b1;
    tick();
    abort_in = 1'b0;
    check("abort_cs0", cs0_n_out, 1'b1);
    check("abort_sck0", sck0_out, 1'b0);
    check("abort_sdo0", sdo0_out, 1'b0);
    check("abort_busy", busy_out, 1'b0);
    s_done = n_done;
    repeat (30) tick();
    check("abort_no_done", n_done - s_done, 0);
    check("abort_result_kept", result_out, 16'h1234);
    pulse_start(16'h3C3C);
    wait_done(400, got);
    check("after_abort_done", got, 1'b1);
    check("after_abort_result", result_out, 16'h5A0F);
    tick();

    // start re-asserted during the job frame
    resp = 16'hC001;
    s_fall = n_cs0_fall; s_done = n_done;
    pulse_start(16'h8001);
    repeat (10) tick();
    start_in = 1'b1; job_in = 16'hFFFF;
    repeat (3) tick();
    start_in = 1'b0;
    wait_done(400, got);
    check("restart_done", got, 1'b1);
    repeat (20) tick();
    check("restart_frames", n_cs0_fall - s_fall, 1);
    check("restart_done_count", n_done - s_done, 1);
    check("restart_result", result_out, 16'hC001);

    // async reset during the result frame
    resp = 16'h7E81;
    pulse_start(16'h1111);
    got = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (!cs1_n_out) begin got = 1; break; end
    end
    check("rst_reached_res", got, 1'b1);
    repeat (7) tick();
    check("rst_in_res", cs1_n_out, 1'b0);
    #1 reset_n_in = 1'b0;
    #1 check_reset_values("midreset");
    tick();
    tick();
    reset_n_in = 1'b1;
    tick();
    resp = 16'h0BAD;
    pulse_start(16'h2222);
    wait_done(400, got);
    check("rst_recover_done", got, 1'b1);
    check("rst_recover_result", result_out, 16'h0BAD);

    // back-to-back start in the cycle after done
    tick();
    resp = 16'hD00D;
    s_fall = n_cs0_fall;
    job_in = 16'h4321; start_in = 1'b1;
    tick();
    start_in = 1'b0;
    check("b2b_cs0", cs0_n_out, 1'b0);
    check("b2b_busy", busy_out, 1'b1);
    wait_done(400, got);
    check("b2b_done", got, 1'b1);
    check("b2b_result", result_out, 16'hD00D);
    tick();

    // randomized transactions, checked cycle by cycle against the model
    for (int t = 0; t < 25; t++) begin
      int sel;
      resp = N'($urandom);
      sel  = int'($urandom_range(0, 9));
      rdy_delay = (sel == 0) ? -1 : (sel < 3) ? -2 : int'($urandom_range(0, 40));
      abort_at  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 180)) : -1;
      pulse_start(J'($urandom));
      got = 0;
      for (int c = 0; c < 400; c++) begin
        if (c == abort_at) abort_in = 1'b1;
        if ($urandom_range(0, 15) == 0) begin start_in = 1'b1; job_in = J'($urandom); end
        tick();
        abort_in = 1'b0;
        start_in = 1'b0;
        if (done_out || !busy_out) begin got = 1; break; end
      end
      check("rand_end", got, 1'b1);
      tick();
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (passed %0d of %0d)", n_pass, n_total);
    $fatal(1);
  end

endmodule
`default_nettype wire
